// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } exu_state_t;

endpackage

// File: rtl/hazard_forward.sv
// rtl/hazard_forward.sv - Execute-stage forwarding select for one source operand
module hazard_forward
  import hazard_pkg::*;
#(
  parameter int A_WIDTH = 5
) (
  input  logic [A_WIDTH-1:0] i_rs,
  input  logic [A_WIDTH-1:0] i_rd_m,
  input  logic [A_WIDTH-1:0] i_rd_w,
  input  logic               i_reg_write_m,
  input  logic               i_reg_write_w,
  output fwd_sel_t           o_sel
);

  // Memory wins over Writeback because it holds the younger value; x0 never forwards.
  always_comb begin
    o_sel = FWD_NONE;
    if (i_rs != '0) begin
      if (i_reg_write_m && (i_rd_m == i_rs)) begin
        o_sel = FWD_M;
      end else if (i_reg_write_w && (i_rd_w == i_rs)) begin
        o_sel = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall/flush control, EXU busy FSM, watchdog and stall counter
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int D_WIDTH        = 32,
  parameter int A_WIDTH        = 5,
  parameter int MAX_EXU_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_WIDTH-1:0] Rs1D,
  input  logic [A_WIDTH-1:0] Rs2D,
  input  logic [A_WIDTH-1:0] Rs1E,
  input  logic [A_WIDTH-1:0] Rs2E,
  input  logic [A_WIDTH-1:0] RdE,
  input  logic [A_WIDTH-1:0] RdM,
  input  logic [A_WIDTH-1:0] RdW,
  input  logic               RegWriteM,
  input  logic               RegWriteW,
  input  logic [1:0]         ResultSrcE,
  input  logic               PCSrcE,
  input  logic               ExuStartE,
  input  logic               ExuDoneE,
  input  logic               StallCountClr,
  output logic [1:0]         ForwardAE,
  output logic [1:0]         ForwardBE,
  output logic               StallF,
  output logic               StallD,
  output logic               StallE,
  output logic               FlushD,
  output logic               FlushE,
  output logic               FlushM,
  output logic               ExuBusy,
  output logic               ExuTimeout,
  output logic [D_WIDTH-1:0] StallCount
);

  localparam int CW = $clog2(MAX_EXU_CYCLES + 1);

  exu_state_t         r_state;
  logic [CW-1:0]      r_busy_cnt;
  logic               r_timeout;
  logic [D_WIDTH-1:0] r_stall_count;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_lw_stall;
  logic     w_trip;
  logic     w_exu_stall;
  logic     w_busy;

  hazard_forward #(.A_WIDTH(A_WIDTH)) u_fwd_a (
    .i_rs(Rs1E), .i_rd_m(RdM), .i_rd_w(RdW),
    .i_reg_write_m(RegWriteM), .i_reg_write_w(RegWriteW), .o_sel(w_fwd_a)
  );

  hazard_forward #(.A_WIDTH(A_WIDTH)) u_fwd_b (
    .i_rs(Rs2E), .i_rd_m(RdM), .i_rd_w(RdW),
    .i_reg_write_m(RegWriteM), .i_reg_write_w(RegWriteW), .o_sel(w_fwd_b)
  );

  assign ForwardAE = w_fwd_a;
  assign ForwardBE = w_fwd_b;

  assign w_busy      = (r_state == BUSY);
  assign w_lw_stall  = (ResultSrcE == RESULT_SRC_MEM) && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
  assign w_trip      = w_busy && !ExuDoneE && (r_busy_cnt == CW'(MAX_EXU_CYCLES - 1));
  assign w_exu_stall = (!w_busy && ExuStartE && !ExuDoneE) ||
                       (w_busy && !ExuDoneE && !w_trip);

  // Priority: trip > exu stall > branch > load-use; branch and load-use are ignored while BUSY.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (w_trip) begin
      FlushE = 1'b1;
    end else if (w_exu_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (!w_busy && PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (!w_busy && w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ExuStartE && !ExuDoneE && !PCSrcE) begin
            r_state    <= BUSY;
            r_busy_cnt <= '0;
          end
        end
        BUSY: begin
          if (ExuDoneE || w_trip) begin
            r_state <= IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_trip) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (StallCountClr) begin
      r_stall_count <= '0;
    end else if (StallF && (r_stall_count != {D_WIDTH{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign ExuBusy    = w_busy;
  assign ExuTimeout = r_timeout;
  assign StallCount = r_stall_count;

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RV32I core: drives the Execute-stage forwarding selects and the stall and flush controls for every pipeline register. It sequences multi-cycle Execute operations (iterative mul/div) with a BUSY state machine, a timeout watchdog and a performance stall counter. It sits beside the datapath and drives the Fetch, Decode, Execute and Memory pipeline registers.

## Interface
Parameters:
- D_WIDTH, 32, stall-counter width
- A_WIDTH, 5, register address width
- MAX_EXU_CYCLES, 64, BUSY cycles allowed before the watchdog trips

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  A_WIDTH  source registers in Decode
- Rs1E, Rs2E, RdE  in  A_WIDTH  source and destination registers in Execute
- RdM, RdW  in  A_WIDTH  destination registers in Memory and Writeback
- RegWriteM, RegWriteW  in  1  write enables in Memory and Writeback
- ResultSrcE  in  2  result select in Execute; RESULT_SRC_MEM marks a load
- PCSrcE  in  1  branch or jump taken in Execute
- ExuStartE  in  1  a multi-cycle op is in Execute (level)
- ExuDoneE  in  1  multi-cycle result valid this cycle
- StallCountClr  in  1  synchronous clear of StallCount
- ForwardAE, ForwardBE  out  2  operand select: FWD_NONE, FWD_W or FWD_M
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  bubble the IF/ID, ID/EX and EX/MEM registers
- ExuBusy  out  1  state == BUSY
- ExuTimeout  out  1  sticky watchdog error
- StallCount  out  D_WIDTH  cycles with StallF high, saturating

## Operation
- Forwarding is combinational, per operand:
  - Memory stage has priority: RegWriteM && RdM != 0 && RdM == Rs1E → FWD_M.
  - Otherwise the same test on the W signals → FWD_W.
  - Otherwise FWD_NONE. x0 is never forwarded. ForwardBE uses the same rules on Rs2E.
- Load-use: lwStall = ResultSrcE == RESULT_SRC_MEM && RdE != 0 && (RdE == Rs1D || RdE == Rs2D). It asserts StallF, StallD and FlushE for exactly that cycle.
- Branch: PCSrcE → FlushD = FlushE = 1. When PCSrcE and lwStall coincide, the flush wins and StallF/StallD are 0, so the redirect proceeds.
- EXU FSM, states IDLE and BUSY (exu_state_t):
  - IDLE → BUSY when ExuStartE && !ExuDoneE && !PCSrcE.
  - BUSY → IDLE when ExuDoneE, or when the watchdog trips.
  - exuStall = (IDLE && ExuStartE && !ExuDoneE) || (BUSY && !ExuDoneE && !trip).
  - exuStall → StallF = StallD = StallE = 1 and FlushM = 1, so Memory receives bubbles.
  - A zero-latency op (ExuDoneE in the start cycle) causes no stall.
- Watchdog:
  - BusyCnt clears on entry to BUSY and increments each BUSY cycle.
  - trip = BUSY && !ExuDoneE && BusyCnt == MAX_EXU_CYCLES-1.
  - On trip: stalls drop, FlushE = 1 (the op is killed), ExuTimeout sets and stays set until reset.
- Priority when several conditions hold: trip > exuStall > PCSrcE > lwStall. While BUSY, PCSrcE and lwStall are ignored.
- StallCount:
  - Increments on each cycle with StallF = 1 and saturates at all ones.
  - StallCountClr clears it and wins over the increment.

## Timing
- Reset values: state IDLE, BusyCnt 0, ExuTimeout 0, StallCount 0. With all inputs idle, every output is 0 and both forward selects are FWD_NONE.
- Forward, stall and flush outputs are combinational from inputs and state, with zero latency. StallCount and ExuTimeout are registered and update one edge after the event.
- A load-use stall lasts 1 cycle. An N-cycle EXU op with ExuDoneE on cycle N stalls cycles 1..N-1.
- Reset mid-BUSY returns to IDLE immediately (asynchronous) and drops all stalls.

## Structure
- hazard_pkg holds:
  - fwd_sel_t: FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - RESULT_SRC_MEM = 2'b01.
  - exu_state_t.
- Sub-module hazard_forward is the combinational select for one operand, instantiated twice (A and B).
- The FSM, watchdog and counter live in hazard_unit.

## Test plan
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=FWD_M. Repeat with RdM=0, Rs1E=0 → FWD_NONE.
- ResultSrcE=01, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle, StallCount +1.
- Same load-use condition with PCSrcE=1 → FlushD=FlushE=1, StallF=StallD=0.
- ExuStartE raised, ExuDoneE on the 4th cycle → StallF/D/E and FlushM high for 3 cycles, ExuBusy high for cycles 2-4, then IDLE.
- MAX_EXU_CYCLES=8 with ExuDoneE never raised → trip after 8 BUSY cycles, FlushE=1, ExuTimeout=1 held, state IDLE.
- StallCount preloaded near all ones with continuous stalls → saturates. StallCountClr → 0. rst_n low mid-BUSY → all outputs reset.
